fp16_fixed_align: RTL

Sequential front end of the fp16-to-fixed conversion path in the attention-layer exponent/softmax datapath. It accepts one IEEE half-precision word per transaction and unpacks it. It computes the unbiased signed exponent and aligns the 11-bit significand into a 28-bit integer magnitude with an iterative one-bit-per-cycle shifter. The resulting `z` and `a_e` drive the combinational saturate/zero output stage directly downstream, which emits `z[15:0]`. It zeroes when `a_e == 6'b10_1111` and saturates to 16'hFFFF when `a_e` is positive and greater than 15.

---
 rtl/fp16_fixed_align.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fp16_fixed_align.sv
// rtl/fp16_fixed_align.sv - fp16 unpack and iterative significand alignment to a 28-bit integer magnitude
module fp16_fixed_align #(
    parameter int DWIDTH   = 16,
    parameter int ZWIDTH   = 28,
    parameter int EXP_BIAS = 15
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ZWIDTH-1:0] z,
    output logic [5:0]        a_e,
    output logic              out_sign,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UNPACK = 2'd1,
        S_SHIFT  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Special exponent codes handed to the saturate/zero stage downstream
    localparam logic [5:0] AE_ZERO = 6'b10_1111;
    localparam logic [5:0] AE_INF  = 6'b01_0000;

    state_t              state_q, state_d;
    logic [DWIDTH-1:0]   data_q, data_d;
    logic [ZWIDTH-1:0]   z_q, z_d;
    logic [5:0]          a_e_q, a_e_d;
    logic                sign_q, sign_d;
    logic [3:0]          count_q, count_d;
    logic                left_q, left_d;

    // Decoded view of the latched operand, consumed only in UNPACK
    logic [4:0]          exp_f;
    logic [9:0]          frac_f;
    logic [5:0]          up_a_e;
    logic [ZWIDTH-1:0]   up_z;
    logic [3:0]          up_count;
    logic                up_left;

    assign exp_f  = data_q[14:10];
    assign frac_f = data_q[9:0];

    // Unpack: exponent classification, significand load and shift plan
    always_comb begin
        up_a_e   = 6'({1'b0, exp_f}) - 6'(EXP_BIAS);
        up_z     = '0;
        up_count = 4'd0;
        up_left  = 1'b0;
        if (exp_f == 5'd0) begin
            up_a_e = AE_ZERO;
        end else if (exp_f == 5'd31) begin
            up_a_e = AE_INF;
        end else begin
            up_z = {17'b0, 1'b1, frac_f};
            if (exp_f >= 5'd25) begin
                // a_e >= 10: integer part needs more bits than the significand holds
                up_left  = 1'b1;
                up_count = 4'(exp_f - 5'd25);
            end else if (exp_f < 5'd14) begin
                // Shifting the hidden bit out entirely takes 11 steps; more would be wasted cycles
                up_count = 4'd11;
            end else begin
                up_count = 4'(5'd25 - exp_f);
            end
        end
    end

    // State register and datapath flops, asynchronously cleared
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            z_q     <= '0;
            a_e_q   <= '0;
            sign_q  <= 1'b0;
            count_q <= '0;
            left_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            z_q     <= z_d;
            a_e_q   <= a_e_d;
            sign_q  <= sign_d;
            count_q <= count_d;
            left_q  <= left_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_valid)             state_d = S_UNPACK;
            S_UNPACK: state_d = (up_count == 4'd0) ? S_DONE : S_SHIFT;
            S_SHIFT:  if (count_q <= 4'd1)      state_d = S_DONE;
            S_DONE:   if (out_ready)            state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath updates: latch operand, load unpacked fields, one-bit shift per cycle
    always_comb begin
        data_d  = data_q;
        z_d     = z_q;
        a_e_d   = a_e_q;
        sign_d  = sign_q;
        count_d = count_q;
        left_d  = left_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) data_d = in_data;
            end
            S_UNPACK: begin
                z_d     = up_z;
                a_e_d   = up_a_e;
                sign_d  = data_q[DWIDTH-1];
                count_d = up_count;
                left_d  = up_left;
            end
            S_SHIFT: begin
                z_d     = left_q ? (z_q << 1) : (z_q >> 1);
                count_d = count_q - 4'd1;
            end
            default: ;
        endcase
    end

    // Outputs: handshakes decoded from state only
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        z         = z_q;
        a_e       = a_e_q;
        out_sign  = sign_q;
    end

endmodule
